// File: rtl/enemy_projectile_ctrl_pkg.sv
// Shared geometry constants and projectile record for the enemy-shot path.
// The engine and renderer import the same values so hit boxes and sprites agree.
package enemy_projectile_ctrl_pkg;

  localparam int Y_MAX        = 119;
  localparam int JOG_Y        = 112;
  localparam int JOG_LARG     = 8;
  localparam int JOG_ALT      = 4;
  localparam int ESPACO_X     = 16;
  localparam int LARG_INIMIGO = 8;
  localparam int ALT_INIMIGO  = 8;
  localparam int VIDAS_INI    = 3;

  typedef struct packed {
    logic       ativo;
    logic [7:0] x;
    logic [7:0] y;
  } tiro_t;

  // Player hit box test; y is the already-advanced row, x range computed 9-bit
  // so a player near the right edge does not wrap.
  function automatic logic acerta_jogador(input logic [7:0] x, input logic [8:0] y,
                                          input logic [7:0] jog_x);
    logic [8:0] x_lo;
    logic [8:0] x_hi;
    x_lo = {1'b0, jog_x};
    x_hi = x_lo + 9'(JOG_LARG - 1);
    return ({1'b0, x} >= x_lo) && ({1'b0, x} <= x_hi) &&
           (y >= 9'(JOG_Y)) && (y <= 9'(JOG_Y + JOG_ALT - 1));
  endfunction

endpackage

// File: rtl/enemy_projectile_ctrl_onehot_to_idx.sv
// Lowest-set-bit priority encoder: returns the index of the lowest 1 and a valid flag.
module enemy_projectile_ctrl_onehot_to_idx #(
  parameter int WIDTH = 6,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enemy_projectile_ctrl.sv
// Enemy projectile pool: spawns shots under the firing enemy, moves them down on a
// fixed tick, and tracks player hits and remaining lives.
module enemy_projectile_ctrl
  import enemy_projectile_ctrl_pkg::*;
#(
  parameter int N_INIMIGOS = 6,
  parameter int MAX_TIROS  = 4,
  parameter int PASSO_DIV  = 500000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    restart,
  input  logic                    pausa,
  input  logic                    tiro_req,
  input  logic [N_INIMIGOS-1:0]   ID_enemy_tiro,
  input  logic [7:0]              bloco_pos_X,
  input  logic [7:0]              bloco_pos_Y,
  input  logic [7:0]              jogador_x,
  output logic [MAX_TIROS-1:0]    tiro_ativo,
  output logic [8*MAX_TIROS-1:0]  tiro_pos_X,
  output logic [8*MAX_TIROS-1:0]  tiro_pos_Y,
  output logic                    jogador_atingido,
  output logic [1:0]              vidas,
  output logic                    jogador_vivo,
  output logic                    tiro_descartado
);

  localparam int CNT_W  = (PASSO_DIV > 1) ? $clog2(PASSO_DIV) : 1;
  localparam int IDX_W  = (N_INIMIGOS > 1) ? $clog2(N_INIMIGOS) : 1;
  localparam int SLOT_W = (MAX_TIROS > 1) ? $clog2(MAX_TIROS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PASSO_DIV - 1);

  tiro_t            slot_q [MAX_TIROS];
  tiro_t            slot_d [MAX_TIROS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       vidas_q, vidas_d;
  logic             atingido_q, atingido_d;
  logic             descartado_q, descartado_d;

  logic [IDX_W-1:0]  k_idx;
  logic              k_valid;
  logic [9:0]        spawn_x;
  logic [8:0]        spawn_y;
  logic [8:0]        y_next [MAX_TIROS];
  logic [MAX_TIROS-1:0] hit_vec;
  logic              tick;
  logic              any_hit;
  logic              livre_found;
  logic [SLOT_W-1:0] livre_idx;

  enemy_projectile_ctrl_onehot_to_idx #(
    .WIDTH (N_INIMIGOS),
    .IDX_W (IDX_W)
  ) u_onehot_to_idx (
    .vec   (ID_enemy_tiro),
    .idx   (k_idx),
    .valid (k_valid)
  );

  assign spawn_x = {2'b00, bloco_pos_X} + (10'(k_idx) * 10'(ESPACO_X)) + 10'(LARG_INIMIGO / 2);
  assign spawn_y = {1'b0, bloco_pos_Y} + 9'(ALT_INIMIGO);
  assign tick    = (cnt_q == CNT_MAX);

  generate
    for (genvar gi = 0; gi < MAX_TIROS; gi++) begin : g_slot
      assign y_next[gi]  = {1'b0, slot_q[gi].y} + 9'd1;
      assign hit_vec[gi] = slot_q[gi].ativo && acerta_jogador(slot_q[gi].x, y_next[gi], jogador_x);
      assign tiro_ativo[gi]          = slot_q[gi].ativo;
      assign tiro_pos_X[8*gi +: 8]   = slot_q[gi].x;
      assign tiro_pos_Y[8*gi +: 8]   = slot_q[gi].y;
    end
  endgenerate

  // Free-slot search looks at the registered flags, so a slot freed this cycle
  // only becomes reusable on the next one.
  always_comb begin
    livre_found = 1'b0;
    livre_idx   = '0;
    for (int i = MAX_TIROS - 1; i >= 0; i--) begin
      if (!slot_q[i].ativo) begin
        livre_found = 1'b1;
        livre_idx   = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    vidas_d      = vidas_q;
    atingido_d   = 1'b0;
    descartado_d = 1'b0;
    any_hit      = 1'b0;

    if (restart) begin
      cnt_d   = '0;
      vidas_d = 2'(VIDAS_INI);
      for (int i = 0; i < MAX_TIROS; i++) slot_d[i] = '0;
    end else if (!pausa) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;

      if (tick) begin
        for (int i = 0; i < MAX_TIROS; i++) begin
          if (slot_q[i].ativo) begin
            slot_d[i].y = y_next[i][7:0];
            if (y_next[i] > 9'(Y_MAX) || hit_vec[i]) slot_d[i].ativo = 1'b0;
            if (hit_vec[i]) any_hit = 1'b1;
          end
        end
      end

      // Spawn is applied after movement so the new shot lands unmoved and untested.
      if (tiro_req && k_valid) begin
        if (!livre_found || spawn_x > 10'd255 || spawn_y > 9'(Y_MAX)) begin
          descartado_d = 1'b1;
        end else begin
          slot_d[livre_idx].ativo = 1'b1;
          slot_d[livre_idx].x     = spawn_x[7:0];
          slot_d[livre_idx].y     = spawn_y[7:0];
        end
      end

      if (any_hit) begin
        atingido_d = 1'b1;
        if (vidas_q != 2'd0) vidas_d = vidas_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      vidas_q      <= 2'(VIDAS_INI);
      atingido_q   <= 1'b0;
      descartado_q <= 1'b0;
      for (int i = 0; i < MAX_TIROS; i++) slot_q[i] <= '0;
    end else begin
      cnt_q        <= cnt_d;
      vidas_q      <= vidas_d;
      atingido_q   <= atingido_d;
      descartado_q <= descartado_d;
      for (int i = 0; i < MAX_TIROS; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign jogador_atingido = atingido_q;
  assign tiro_descartado  = descartado_q;
  assign vidas            = vidas_q;
  assign jogador_vivo     = (vidas_q != 2'd0);

endmodule

// File: tb/tb_enemy_projectile_ctrl.sv
// Directed bench for enemy_projectile_ctrl with a 4-cycle movement tick.
module tb_enemy_projectile_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        restart;
  logic        pausa;
  logic        tiro_req;
  logic [5:0]  ID_enemy_tiro;
  logic [7:0]  bloco_pos_X;
  logic [7:0]  bloco_pos_Y;
  logic [7:0]  jogador_x;
  logic [3:0]  tiro_ativo;
  logic [31:0] tiro_pos_X;
  logic [31:0] tiro_pos_Y;
  logic        jogador_atingido;
  logic [1:0]  vidas;
  logic        jogador_vivo;
  logic        tiro_descartado;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  enemy_projectile_ctrl #(
    .N_INIMIGOS (6),
    .MAX_TIROS  (4),
    .PASSO_DIV  (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .restart          (restart),
    .pausa            (pausa),
    .tiro_req         (tiro_req),
    .ID_enemy_tiro    (ID_enemy_tiro),
    .bloco_pos_X      (bloco_pos_X),
    .bloco_pos_Y      (bloco_pos_Y),
    .jogador_x        (jogador_x),
    .tiro_ativo       (tiro_ativo),
    .tiro_pos_X       (tiro_pos_X),
    .tiro_pos_Y       (tiro_pos_Y),
    .jogador_atingido (jogador_atingido),
    .vidas            (vidas),
    .jogador_vivo     (jogador_vivo),
    .tiro_descartado  (tiro_descartado)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Restart sampled at edge E0; the tick then lands on edges E4, E8, E12, ...
  task automatic do_restart();
    restart  = 1'b1;
    tiro_req = 1'b0;
    step();
    restart = 1'b0;
  endtask

  task automatic fire(input logic [5:0] id);
    tiro_req      = 1'b1;
    ID_enemy_tiro = id;
  endtask

  // Three projectiles in flight with one life left, stopped just before the tick at E12.
  task automatic setup_mid();
    jogador_x   = 8'd42;
    bloco_pos_X = 8'd10;
    bloco_pos_Y = 8'd103;
    do_restart();
    for (int h = 0; h < 2; h++) begin
      fire(6'b000100);
      step();
      tiro_req = 1'b0;
      repeat (3) step();
    end
    jogador_x = 8'd200;
    fire(6'b000100);
    repeat (3) step();
    tiro_req = 1'b0;
    check_eq("mid_ativo", {28'd0, tiro_ativo}, 32'h7);
    check_eq("mid_vidas", {30'd0, vidas}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; pausa = 1'b0; tiro_req = 1'b0;
    ID_enemy_tiro = '0; bloco_pos_X = 8'd10; bloco_pos_Y = 8'd20; jogador_x = 8'd200;
    #12 reset = 1'b0;
    step();
    check_eq("rst_ativo", {28'd0, tiro_ativo}, 32'h0);
    check_eq("rst_vidas", {30'd0, vidas}, 32'd3);
    check_eq("rst_vivo", {31'd0, jogador_vivo}, 32'd1);
    check_eq("rst_posx", tiro_pos_X, 32'h0);
    check_eq("rst_pulses", {30'd0, jogador_atingido, tiro_descartado}, 32'd0);

    // Spawn position
    do_restart();
    fire(6'b000100);
    step();
    tiro_req = 1'b0;
    check_eq("spawn_ativo", {28'd0, tiro_ativo}, 32'h1);
    check_eq("spawn_x", {24'd0, tiro_pos_X[7:0]}, 32'd46);
    check_eq("spawn_y", {24'd0, tiro_pos_Y[7:0]}, 32'd28);

    // Movement and off-screen
    bloco_pos_X = 8'd0; bloco_pos_Y = 8'd109;
    do_restart();
    fire(6'b000001);
    step();
    tiro_req = 1'b0;
    check_eq("move_y0", {24'd0, tiro_pos_Y[7:0]}, 32'd117);
    repeat (2) step();
    check_eq("move_y_e3", {24'd0, tiro_pos_Y[7:0]}, 32'd117);
    step();
    check_eq("move_y_e4", {24'd0, tiro_pos_Y[7:0]}, 32'd118);
    repeat (4) step();
    check_eq("move_y_e8", {24'd0, tiro_pos_Y[7:0]}, 32'd119);
    check_eq("move_ativo_e8", {28'd0, tiro_ativo}, 32'h1);
    repeat (4) step();
    check_eq("move_off_e12", {28'd0, tiro_ativo}, 32'h0);

    // Single hit
    jogador_x = 8'd42; bloco_pos_X = 8'd10; bloco_pos_Y = 8'd103;
    do_restart();
    fire(6'b000100);
    step();
    tiro_req = 1'b0;
    repeat (2) step();
    check_eq("hit_pre_pulse", {31'd0, jogador_atingido}, 32'd0);
    step();
    check_eq("hit_ativo", {28'd0, tiro_ativo}, 32'h0);
    check_eq("hit_pulse", {31'd0, jogador_atingido}, 32'd1);
    check_eq("hit_vidas", {30'd0, vidas}, 32'd2);
    step();
    check_eq("hit_pulse_end", {31'd0, jogador_atingido}, 32'd0);

    // Double hit on one tick plus a spawn in the tick cycle
    do_restart();
    fire(6'b000100);
    repeat (2) step();
    tiro_req = 1'b0;
    step();
    check_eq("dbl_pre_ativo", {28'd0, tiro_ativo}, 32'h3);
    fire(6'b000100);
    step();
    tiro_req = 1'b0;
    check_eq("dbl_ativo", {28'd0, tiro_ativo}, 32'h4);
    check_eq("dbl_vidas", {30'd0, vidas}, 32'd2);
    check_eq("dbl_pulse", {31'd0, jogador_atingido}, 32'd1);
    check_eq("dbl_new_y", {24'd0, tiro_pos_Y[23:16]}, 32'd111);
    repeat (4) step();
    check_eq("late_hit_ativo", {28'd0, tiro_ativo}, 32'h0);
    check_eq("late_hit_vidas", {30'd0, vidas}, 32'd1);

    // Pool full and request filtering
    jogador_x = 8'd200; bloco_pos_X = 8'd10; bloco_pos_Y = 8'd20;
    do_restart();
    fire(6'b000001);
    repeat (4) step();
    check_eq("pool_ativo", {28'd0, tiro_ativo}, 32'hF);
    check_eq("pool_nodrop", {31'd0, tiro_descartado}, 32'd0);
    step();
    check_eq("pool_drop", {31'd0, tiro_descartado}, 32'd1);
    tiro_req = 1'b0;
    step();
    check_eq("pool_drop_end", {31'd0, tiro_descartado}, 32'd0);

    do_restart();
    fire(6'b000000);
    step();
    check_eq("id0_ativo", {28'd0, tiro_ativo}, 32'h0);
    check_eq("id0_nodrop", {31'd0, tiro_descartado}, 32'd0);
    fire(6'b100100);
    step();
    check_eq("idmulti_ativo", {28'd0, tiro_ativo}, 32'h1);
    check_eq("idmulti_x", {24'd0, tiro_pos_X[7:0]}, 32'd46);
    bloco_pos_X = 8'd250;
    fire(6'b000010);
    step();
    check_eq("sx_over_drop", {31'd0, tiro_descartado}, 32'd1);
    check_eq("sx_over_ativo", {28'd0, tiro_ativo}, 32'h1);
    fire(6'b000001);
    step();
    check_eq("sx_254_x", {24'd0, tiro_pos_X[15:8]}, 32'd254);
    check_eq("sx_254_nodrop", {31'd0, tiro_descartado}, 32'd0);
    bloco_pos_X = 8'd10; bloco_pos_Y = 8'd112;
    step();
    check_eq("sy_over_drop", {31'd0, tiro_descartado}, 32'd1);
    bloco_pos_Y = 8'd111;
    step();
    tiro_req = 1'b0;
    check_eq("sy_119_ativo", {28'd0, tiro_ativo}, 32'h7);
    check_eq("sy_119_y", {24'd0, tiro_pos_Y[23:16]}, 32'd119);

    // Lives down to zero, then freeze
    jogador_x = 8'd42; bloco_pos_X = 8'd10; bloco_pos_Y = 8'd103;
    do_restart();
    for (int h = 0; h < 4; h++) begin
      fire(6'b000100);
      step();
      tiro_req = 1'b0;
      repeat (3) step();
      check_eq($sformatf("lives_pulse%0d", h), {31'd0, jogador_atingido}, 32'd1);
      check_eq($sformatf("lives_vidas%0d", h), {30'd0, vidas}, (h >= 2) ? 32'd0 : 32'(2 - h));
    end
    check_eq("lives_vivo", {31'd0, jogador_vivo}, 32'd0);
    fire(6'b000100);
    step();
    tiro_req = 1'b0;
    pausa = 1'b1;
    ID_enemy_tiro = 6'b000001;
    for (int i = 0; i < 20; i++) begin
      tiro_req = (i == 5);
      step();
    end
    tiro_req = 1'b0;
    check_eq("pause_ativo", {28'd0, tiro_ativo}, 32'h1);
    check_eq("pause_y", {24'd0, tiro_pos_Y[7:0]}, 32'd111);
    check_eq("pause_nodrop", {31'd0, tiro_descartado}, 32'd0);
    check_eq("pause_vidas", {30'd0, vidas}, 32'd0);
    pausa = 1'b0;

    // Asynchronous reset mid-flight
    setup_mid();
    #3 reset = 1'b1;
    #1;
    check_eq("arst_ativo", {28'd0, tiro_ativo}, 32'h0);
    check_eq("arst_vidas", {30'd0, vidas}, 32'd3);
    check_eq("arst_vivo", {31'd0, jogador_vivo}, 32'd1);
    check_eq("arst_posy", tiro_pos_Y, 32'h0);
    #1 reset = 1'b0;
    step();

    // Synchronous restart mid-flight
    setup_mid();
    restart = 1'b1;
    #1;
    check_eq("rstrt_hold", {28'd0, tiro_ativo}, 32'h7);
    step();
    restart = 1'b0;
    check_eq("rstrt_ativo", {28'd0, tiro_ativo}, 32'h0);
    check_eq("rstrt_vidas", {30'd0, vidas}, 32'd3);
    check_eq("rstrt_vivo", {31'd0, jogador_vivo}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/enemy_projectile_ctrl.md
Name: enemy_projectile_ctrl

Overview:
Manages enemy shots downstream of the game engine. Takes each fire request (one-hot shooter ID) and spawns a projectile below that enemy in the formation. Moves all live projectiles down on a fixed tick and detects hits on the player. Produces player hit, lives and jogador_vivo, which feed back into the engine's game-state logic.

Parameters:
N_INIMIGOS, 6, number of enemies in the formation (width of shooter ID)
MAX_TIROS, 4, projectile slots in the pool
ESPACO_X, 16, horizontal pitch between enemies (pixels)
LARG_INIMIGO, 8, enemy width; spawn X offset = LARG_INIMIGO/2
ALT_INIMIGO, 8, enemy height; spawn Y offset
PASSO_DIV, 500000, clk cycles per movement tick (bench overrides to 4)
Y_MAX, 119, last visible row
JOG_Y, 112, player top row
JOG_LARG, 8, player width
JOG_ALT, 4, player height
VIDAS_INI, 3, lives after reset/restart

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
restart  in  1  synchronous clear from engine, same effect as reset
pausa  in  1  1 = game not running (estado_jogo != 0): freeze all state
tiro_req  in  1  one-cycle strobe: fire request valid
ID_enemy_tiro  in  N_INIMIGOS  one-hot shooter ID, sampled when tiro_req=1
bloco_pos_X  in  8  formation top-left X
bloco_pos_Y  in  8  formation top-left Y
jogador_x  in  8  player left X
tiro_ativo  out  MAX_TIROS  per-slot active flag
tiro_pos_X  out  8*MAX_TIROS  slot i at bits [8i+7:8i]
tiro_pos_Y  out  8*MAX_TIROS  same packing
jogador_atingido  out  1  one-cycle pulse on hit
vidas  out  2  remaining lives
jogador_vivo  out  1  vidas != 0
tiro_descartado  out  1  one-cycle pulse when a request is dropped

Behaviour:
- Reset (async) or restart (sync): tiro_ativo=0, all positions 0, tick counter 0, vidas=VIDAS_INI, pulses 0, jogador_vivo=1. Reset asserted mid-flight kills all projectiles immediately.
- pausa=1: counter, slots and lives hold. tiro_req is ignored with no drop pulse.
- Tick counter: 0..PASSO_DIV-1. Tick fires in the cycle the counter equals PASSO_DIV-1, then the counter wraps to 0.
- Spawn, registered, 1-cycle latency (slot visible the cycle after tiro_req):
  - k = index of the lowest set bit of ID_enemy_tiro. ID=0: ignore, no pulse.
  - sx = bloco_pos_X + k*ESPACO_X + LARG_INIMIGO/2; sy = bloco_pos_Y + ALT_INIMIGO. Both computed at 9+ bits.
  - Target slot: lowest-index inactive slot.
  - Drop (tiro_descartado=1) if no slot is free, sx>255, or sy>Y_MAX.
- Movement on tick: every active slot gets Y+1. If new Y>Y_MAX, the slot deactivates.
- Hit test on tick, using the new Y. A slot hits if:
  - jogador_x <= X <= jogador_x+JOG_LARG-1, computed 9-bit, and
  - JOG_Y <= Y <= JOG_Y+JOG_ALT-1.
  - Every hitting slot deactivates.
  - If at least one hit: jogador_atingido=1 for one cycle, and vidas decrements by exactly 1 even for multiple simultaneous hits. vidas saturates at 0.
- Spawn and tick in the same cycle:
  - Existing slots move first.
  - The new projectile is written at (sx,sy) unmoved and is not hit-tested that cycle.
  - A slot freed by off-screen or hit in that cycle is not reusable until the next cycle.
- vidas=0: jogador_vivo=0. Projectiles keep moving until the engine asserts pausa or restart; further hits do not change vidas but still pulse jogador_atingido.

Decomposition:
- Shared package: screen/player geometry constants (Y_MAX, JOG_Y, JOG_LARG, JOG_ALT), ESPACO_X/LARG_INIMIGO/ALT_INIMIGO, and a projectile record type {ativo, x[7:0], y[7:0]}. The engine and renderer use the same constants.
- One sub-module: onehot_to_idx (lowest-set-bit priority encoder, parameterised width, emits index and valid).

Test Plan:
1. Spawn position: bloco=(10,20), ID=6'b000100, tiro_req pulse -> next cycle tiro_ativo=4'b0001, slot0=(46,28).
2. Movement: after 1 spawn with PASSO_DIV=4 -> slot0 Y increments by 1 every 4 cycles. Starting at sy=117, the slot is at Y=119 after 2 ticks and inactive after the 3rd tick.
3. Hit: jogador_x=42, projectile at (46,111) -> next tick Y=112, slot cleared, jogador_atingido pulse, vidas 3->2. Two projectiles hitting on the same tick -> vidas drops by 1 only.
4. Pool full: 5 requests with no tick -> slots 0-3 active, 5th gives tiro_descartado pulse. ID=0 with tiro_req -> no spawn, no pulse. ID=6'b100100 -> k=2.
5. Lives/freeze: three separate hits -> vidas=0, jogador_vivo=0. With pausa=1 for 20 cycles, positions are unchanged and tiro_req is ignored.
6. Reset/restart mid-flight: 3 active projectiles, vidas=1, assert reset asynchronously between clock edges -> outputs clear immediately, vidas=3. Repeat with restart -> clears on the next edge.
